// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: CPU-facing register window for the UART block.
// Decodes the 32-byte register window, sequences TX FIFO pushes and RX FIFO
// pops, stalls TXDATA stores on a full FIFO (bounded by a timeout), and owns
// the baud divisor, the sticky error flags and the interrupt line.
module uart_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned DEFAULT_DIV = 868,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned TX_TIMEOUT  = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 req_ready,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 tx_push,
    output logic [7:0]           tx_data,
    input  logic                 tx_full,
    input  logic                 tx_empty,
    input  logic                 tx_busy,
    output logic                 rx_pop,
    input  logic [7:0]           rx_data,
    input  logic                 rx_empty,
    input  logic                 rx_overrun,
    output logic [DIV_WIDTH-1:0] baud_div,
    output logic                 irq
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TX_WAIT = 2'd1,
        S_RX_POP  = 2'd2
    } state_e;

    localparam logic [4:0] OFF_TXDATA = 5'h00;
    localparam logic [4:0] OFF_RXDATA = 5'h04;
    localparam logic [4:0] OFF_STATUS = 5'h08;
    localparam logic [4:0] OFF_CTRL   = 5'h0C;
    localparam logic [4:0] OFF_BAUD   = 5'h10;

    localparam int unsigned      CNT_W    = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO  = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    // FSM and registered response/strobe outputs
    state_e              state_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [31:0]         rsp_rdata_q;
    logic                tx_push_q;
    logic [7:0]          tx_data_q;
    logic                rx_pop_q;
    logic [7:0]          hold_q;
    logic [CNT_W-1:0]    cnt_q;

    // Architectural registers with their next-state values
    logic [2:0]          ctrl_q;
    logic [2:0]          ctrl_d;
    logic                overrun_q;
    logic                overrun_d;
    logic                drop_q;
    logic                drop_d;
    logic [DIV_WIDTH-1:0] baud_q;
    logic [DIV_WIDTH-1:0] baud_d;
    logic                irq_q;
    logic                irq_d;

    // Decode helpers
    logic [4:0]          offset_s;
    logic                addr_ok_s;
    logic                accept_s;
    logic                wr_ctrl_s;
    logic                wr_baud_s;
    logic                timeout_s;
    logic [31:0]         status_s;
    logic [31:0]         rdata_s;

    // Only the window offset matters; upper address bits arrive pre-decoded
    logic                unused_s;
    assign unused_s = ^{req_addr[31:5], req_wdata, BASE_ADDR};

    assign offset_s  = req_addr[4:0];
    assign req_ready = (state_q == S_IDLE);
    assign accept_s  = req_valid & req_ready;
    assign wr_ctrl_s = accept_s & req_we & addr_ok_s & (offset_s == OFF_CTRL);
    assign wr_baud_s = accept_s & req_we & addr_ok_s & (offset_s == OFF_BAUD);
    // Last allowed stall cycle with the FIFO still full: give up on the store
    assign timeout_s = (state_q == S_TX_WAIT) & tx_full & (cnt_q == CNT_LAST);
    assign status_s  = {26'h0, drop_q, overrun_q, tx_empty, tx_busy, ~rx_empty, tx_full};

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign tx_push   = tx_push_q;
    assign tx_data   = tx_data_q;
    assign rx_pop    = rx_pop_q;
    assign baud_div  = baud_q;
    assign irq       = irq_q;

    // Valid offsets are word aligned, so misaligned addresses fall to default
    always_comb begin
        addr_ok_s = 1'b0;
        case (offset_s)
            OFF_TXDATA, OFF_RXDATA, OFF_STATUS, OFF_CTRL, OFF_BAUD: addr_ok_s = 1'b1;
            default:                                                addr_ok_s = 1'b0;
        endcase
    end

    // Load data mux for the register window
    always_comb begin
        rdata_s = 32'h0;
        case (offset_s)
            OFF_RXDATA: begin
                if (rx_empty) begin
                    rdata_s = 32'h8000_0000;
                end else begin
                    rdata_s = {24'h0, rx_data};
                end
            end
            OFF_STATUS: rdata_s = status_s;
            OFF_CTRL:   rdata_s = {29'h0, ctrl_q};
            OFF_BAUD:   rdata_s = 32'(baud_q);
            default:    rdata_s = 32'h0;
        endcase
    end

    // Next state of CTRL, sticky flags, divisor and interrupt; a set beats a W1C clear
    always_comb begin
        ctrl_d    = ctrl_q;
        overrun_d = overrun_q;
        drop_d    = drop_q;
        baud_d    = baud_q;
        if (wr_ctrl_s) begin
            ctrl_d = req_wdata[2:0];
            if (req_wdata[8]) begin
                overrun_d = 1'b0;
            end else begin
                overrun_d = overrun_q;
            end
            if (req_wdata[9]) begin
                drop_d = 1'b0;
            end else begin
                drop_d = drop_q;
            end
        end else begin
            ctrl_d = ctrl_q;
        end
        if (rx_overrun) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_d;
        end
        if (timeout_s) begin
            drop_d = 1'b1;
        end else begin
            drop_d = drop_d;
        end
        if (wr_baud_s) begin
            if (req_wdata[DIV_WIDTH-1:0] == DIV_ZERO) begin
                baud_d = DIV_ONE;
            end else begin
                baud_d = req_wdata[DIV_WIDTH-1:0];
            end
        end else begin
            baud_d = baud_q;
        end
        irq_d = (ctrl_d[0] & ~rx_empty)
              | (ctrl_d[1] & tx_empty & ~tx_busy)
              | (ctrl_d[2] & overrun_d);
    end

    // Architectural registers and the registered interrupt line
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= 3'b000;
            overrun_q <= 1'b0;
            drop_q    <= 1'b0;
            baud_q    <= DIV_RESET;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
            baud_q    <= baud_d;
            irq_q     <= irq_d;
        end
    end

    // Request sequencer: accepts accesses, stalls TX stores, pops RX bytes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            tx_push_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            rx_pop_q    <= 1'b0;
            hold_q      <= 8'h00;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            tx_push_q   <= 1'b0;
            rx_pop_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        if (!addr_ok_s) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (req_we && (offset_s == OFF_TXDATA)) begin
                            if (tx_full) begin
                                hold_q  <= req_wdata[7:0];
                                cnt_q   <= '0;
                                state_q <= S_TX_WAIT;
                            end else begin
                                tx_push_q   <= 1'b1;
                                tx_data_q   <= req_wdata[7:0];
                                rsp_valid_q <= 1'b1;
                            end
                        end else if (!req_we && (offset_s == OFF_RXDATA) && !rx_empty) begin
                            // Pop and respond while blocking the next request for one cycle
                            rx_pop_q    <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rdata_s;
                            state_q     <= S_RX_POP;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            if (req_we) begin
                                rsp_rdata_q <= 32'h0;
                            end else begin
                                rsp_rdata_q <= rdata_s;
                            end
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_TX_WAIT: begin
                    if (!tx_full) begin
                        tx_push_q   <= 1'b1;
                        tx_data_q   <= hold_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_RX_POP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: a table of single-cycle accesses
// plus hand-written sequences for TX stall/timeout, RX back-to-back pops,
// sticky set-vs-clear and reset during a stall. Responses and TX pushes are
// checked against scoreboard queues filled when stimulus is driven.
module tb_uart_mmio_ctrl;

    localparam logic [31:0] BASE       = 32'h1000_0000;
    localparam int          TIMEOUT    = 4096;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        tx_push;
    logic [7:0]  tx_data;
    logic        tx_full;
    logic        tx_empty;
    logic        tx_busy;
    logic        rx_pop;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_overrun;
    logic [15:0] baud_div;
    logic        irq;

    uart_mmio_ctrl #(
        .BASE_ADDR  (BASE),
        .DEFAULT_DIV(868),
        .DIV_WIDTH  (16),
        .TX_TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .tx_push   (tx_push),
        .tx_data   (tx_data),
        .tx_full   (tx_full),
        .tx_empty  (tx_empty),
        .tx_busy   (tx_busy),
        .rx_pop    (rx_pop),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .rx_overrun(rx_overrun),
        .baud_div  (baud_div),
        .irq       (irq)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [4:0]  off;
        logic [31:0] wdata;
        logic        txf;
        logic        txe;
        logic        txb;
        logic        rxe;
        logic [7:0]  rxd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_push;
        logic        exp_pop;
        logic [15:0] exp_baud;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] txq[$];
    vec_t       vq[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_pops   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] off, input logic [31:0] wd,
                                input logic txf, input logic txe, input logic txb,
                                input logic rxe, input logic [7:0] rxd,
                                input logic [31:0] er, input logic ee, input logic ep,
                                input logic eo, input logic [15:0] eb);
        vec_t v;
        v.we = we; v.off = off; v.wdata = wd;
        v.txf = txf; v.txe = txe; v.txb = txb; v.rxe = rxe; v.rxd = rxd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_push = ep; v.exp_pop = eo; v.exp_baud = eb;
        return v;
    endfunction

    function automatic exp_t ex(input logic [31:0] r, input logic e);
        exp_t x;
        x.rdata = r;
        x.err   = e;
        return x;
    endfunction

    // Drive one request and hold it until accepted; returns in the response cycle
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int waits;
        waits     = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && waits < 100) begin
            tick();
            waits++;
        end
        if (!req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_wait: got req_ready=0 expected 1 within 100 cycles");
        end
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
    endtask

    // Scoreboard monitor on the falling edge: responses and pushes in order
    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rsp_unexpected: got rdata=%h err=%b expected no response", rsp_rdata, rsp_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        n_errors++;
                        $display("FAIL rsp: got rdata=%h err=%b expected rdata=%h err=%b",
                                 rsp_rdata, rsp_err, e.rdata, e.err);
                    end
                end
            end
            if (tx_push) begin
                n_checks++;
                if (txq.size() == 0) begin
                    n_errors++;
                    $display("FAIL push_unexpected: got tx_data=%h expected no push", tx_data);
                end else begin
                    logic [7:0] b;
                    b = txq.pop_front();
                    if (tx_data !== b) begin
                        n_errors++;
                        $display("FAIL push_data: got %h expected %h", tx_data, b);
                    end
                end
                if (rx_pop) begin
                    n_errors++;
                    $display("FAIL push_pop_overlap: got both strobes expected at most one");
                end
            end
            if (rx_pop) n_pops++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        tx_full = 1'b0; tx_empty = 1'b1; tx_busy = 1'b0; rx_data = 8'h00; rx_empty = 1'b1;
        rx_overrun = 1'b0;

        // Access table: we, off, wdata, txf, txe, txb, rxe, rxd, rdata, err, push, pop, baud
        vq.push_back(mk(1'b0, 5'h08, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 16'd868));
        vq.push_back(mk(1'b1, 5'h00, 32'h0000_0041, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,          1'b0, 1'b1, 1'b0, 16'd868));
        vq.push_back(mk(1'b0, 5'h00, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,          1'b0, 1'b0, 1'b0, 16'd868));
        vq.push_back(mk(1'b0, 5'h08, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 16'd868));
        vq.push_back(mk(1'b0, 5'h04, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 32'h0000_005A, 1'b0, 1'b0, 1'b1, 16'd868));
        vq.push_back(mk(1'b0, 5'h04, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 16'd868));
        vq.push_back(mk(1'b1, 5'h04, 32'h0000_00FF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 32'h0,          1'b0, 1'b0, 1'b0, 16'd868));
        vq.push_back(mk(1'b1, 5'h10, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,          1'b0, 1'b0, 1'b0, 16'h1234));
        vq.push_back(mk(1'b0, 5'h10, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 16'h1234));
        vq.push_back(mk(1'b1, 5'h10, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,          1'b0, 1'b0, 1'b0, 16'd1));
        vq.push_back(mk(1'b0, 5'h10, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 16'd1));
        vq.push_back(mk(1'b0, 5'h14, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,          1'b1, 1'b0, 1'b0, 16'd1));
        vq.push_back(mk(1'b1, 5'h02, 32'h0000_0077, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,          1'b1, 1'b0, 1'b0, 16'd1));
        vq.push_back(mk(1'b1, 5'h11, 32'h0000_5555, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,          1'b1, 1'b0, 1'b0, 16'd1));
        vq.push_back(mk(1'b0, 5'h1C, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,          1'b1, 1'b0, 1'b0, 16'd1));
        vq.push_back(mk(1'b1, 5'h0C, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,          1'b0, 1'b0, 1'b0, 16'd1));
        vq.push_back(mk(1'b0, 5'h0C, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 16'd1));
        vq.push_back(mk(1'b1, 5'h0C, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,          1'b0, 1'b0, 1'b0, 16'd1));
        vq.push_back(mk(1'b1, 5'h08, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,          1'b0, 1'b0, 1'b0, 16'd1));
        vq.push_back(mk(1'b0, 5'h08, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 16'd1));

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_strobes", {28'h0, rsp_valid, rsp_err, tx_push, rx_pop}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_txdata", {24'h0, tx_data}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_baud", {16'h0, baud_div}, 32'd868);

        // Table-driven single-cycle accesses
        foreach (vq[i]) begin
            tx_full = vq[i].txf; tx_empty = vq[i].txe; tx_busy = vq[i].txb;
            rx_empty = vq[i].rxe; rx_data = vq[i].rxd;
            exp_q.push_back(ex(vq[i].exp_rdata, vq[i].exp_err));
            if (vq[i].exp_push) txq.push_back(vq[i].wdata[7:0]);
            do_req(vq[i].we, BASE | {27'h0, vq[i].off}, vq[i].wdata);
            chk($sformatf("v%0d_latency", i), {31'h0, rsp_valid}, 32'h1);
            chk($sformatf("v%0d_push", i), {31'h0, tx_push}, {31'h0, vq[i].exp_push});
            chk($sformatf("v%0d_pop", i), {31'h0, rx_pop}, {31'h0, vq[i].exp_pop});
            chk($sformatf("v%0d_baud", i), {16'h0, baud_div}, {16'h0, vq[i].exp_baud});
        end
        tx_full = 1'b0; tx_empty = 1'b1; tx_busy = 1'b0; rx_empty = 1'b1; rx_data = 8'h00;
        tick();

        // TX stall for 10 cycles, then the FIFO drains
        tx_full = 1'b1;
        exp_q.push_back(ex(32'h0, 1'b0));
        txq.push_back(8'h55);
        do_req(1'b1, BASE, 32'h0000_0055);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("stall_quiet_%0d", c), {29'h0, req_ready, rsp_valid, tx_push}, 32'h0);
            tick();
        end
        tx_full = 1'b0;
        tick();
        chk("stall_push", {23'h0, tx_push, tx_data}, {23'h0, 1'b1, 8'h55});
        tick();

        // TX timeout with the FIFO held full
        tx_full = 1'b1;
        exp_q.push_back(ex(32'h0, 1'b1));
        do_req(1'b1, BASE, 32'h0000_00AA);
        begin
            int cyc;
            cyc = 1;
            while (!rsp_valid && cyc < 5000) begin
                tick();
                cyc++;
            end
            chk("timeout_cycles", cyc, TIMEOUT + 1);
        end
        tick();
        tx_full = 1'b0;
        exp_q.push_back(ex(32'h0000_0028, 1'b0));
        do_req(1'b0, BASE | 32'h08, 32'h0);
        exp_q.push_back(ex(32'h0, 1'b0));
        do_req(1'b1, BASE | 32'h0C, 32'h0000_0200);
        exp_q.push_back(ex(32'h0000_0008, 1'b0));
        do_req(1'b0, BASE | 32'h08, 32'h0);

        // Back-to-back RXDATA loads: the second must wait out RX_POP
        n_pops   = 0;
        rx_empty = 1'b0;
        rx_data  = 8'h7E;
        exp_q.push_back(ex(32'h0000_007E, 1'b0));
        do_req(1'b0, BASE | 32'h04, 32'h0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = BASE | 32'h04;
        chk("rx_b2b_blocked", {30'h0, req_ready, rx_pop}, 32'h1);
        tick();
        rx_data = 8'h3C;
        chk("rx_b2b_ready", {31'h0, req_ready}, 32'h1);
        exp_q.push_back(ex(32'h0000_003C, 1'b0));
        tick();
        req_valid = 1'b0; req_addr = 32'h0;
        chk("rx_b2b_pop2", {31'h0, rx_pop}, 32'h1);
        tick();
        rx_empty = 1'b1;
        exp_q.push_back(ex(32'h8000_0000, 1'b0));
        do_req(1'b0, BASE | 32'h04, 32'h0);
        tick();
        chk("rx_pop_count", n_pops, 2);

        // Overrun pulse coincides with a W1C clear: set wins, irq follows
        tx_empty = 1'b0;
        rx_overrun = 1'b1;
        exp_q.push_back(ex(32'h0, 1'b0));
        do_req(1'b1, BASE | 32'h0C, 32'h0000_0104);
        rx_overrun = 1'b0;
        chk("ovr_irq_set", {31'h0, irq}, 32'h1);
        exp_q.push_back(ex(32'h0000_0010, 1'b0));
        do_req(1'b0, BASE | 32'h08, 32'h0);
        exp_q.push_back(ex(32'h0, 1'b0));
        do_req(1'b1, BASE | 32'h0C, 32'h0000_0100);
        chk("ovr_irq_clr", {31'h0, irq}, 32'h0);
        exp_q.push_back(ex(32'h0, 1'b0));
        do_req(1'b0, BASE | 32'h08, 32'h0);

        // Reset in the middle of a TX stall abandons the store
        tx_full = 1'b1;
        do_req(1'b1, BASE, 32'h0000_0099);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_stall_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_stall_quiet", {30'h0, rsp_valid, tx_push}, 32'h0);
        chk("rst_stall_baud", {16'h0, baud_div}, 32'd868);
        tx_full = 1'b0;
        repeat (5) tick();

        chk("rsp_queue_empty", exp_q.size(), 0);
        chk("tx_queue_empty", txq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped control front-end for the UART block, between the CPU load/store unit and the UART TX/RX FIFOs. It decodes the 32-byte UART register window and sequences TX FIFO pushes and RX FIFO pops. It stalls stores while the TX FIFO is full, with a timeout, and owns the programmable baud divisor, sticky error flags and the UART interrupt line.

## Interface
Parameters:
- BASE_ADDR, 32'h1000_0000, base of the register window; bits [4:0] must be 0.
- DEFAULT_DIV, 868, baud divisor loaded at reset.
- DIV_WIDTH, 16, width of the baud divisor.
- TX_TIMEOUT, 4096, maximum cycles a TXDATA store may stall on a full FIFO.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  CPU request, pre-decoded to this window
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; only [4:0] used
- req_wdata  in  32  store data
- req_ready  out  1  request accepted when req_valid && req_ready
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid
- tx_push  out  1  one-cycle push strobe to the TX FIFO
- tx_data  out  8  push data
- tx_full  in  1  TX FIFO full
- tx_empty  in  1  TX FIFO empty
- tx_busy  in  1  TX shifter active
- rx_pop  out  1  one-cycle pop strobe to the RX FIFO
- rx_data  in  8  RX FIFO head (first-word fall-through)
- rx_empty  in  1  RX FIFO empty
- rx_overrun  in  1  pulse: byte received while the RX FIFO was full
- baud_div  out  DIV_WIDTH  divisor to the baud generator
- irq  out  1  registered interrupt, level-sensitive

## Operation
Register map (offset: access, meaning):
- 0x00 TXDATA: W pushes wdata[7:0]. R returns 0.
- 0x04 RXDATA: R returns {24'b0, byte} and pops. If the FIFO is empty, returns 32'h8000_0000 with no pop. W is ignored.
- 0x08 STATUS (RO): bit0 tx_full, bit1 !rx_empty, bit2 tx_busy, bit3 tx_empty, bit4 overrun_sticky, bit5 drop_sticky.
- 0x0C CTRL: bit0 rx_irq_en, bit1 tx_irq_en, bit2 ovr_irq_en (RW). Write-1-to-clear on bit8 (overrun_sticky) and bit9 (drop_sticky); both read back 0.
- 0x10 BAUD: RW, [DIV_WIDTH-1:0]. Writing 0 stores 1.
- Any other offset, or req_addr[1:0] != 0: rsp_err=1, rdata=0, no side effects.

FSM states: IDLE, TX_WAIT, RX_POP.
- IDLE: req_ready=1. On accept:
  - TXDATA store with tx_full=0: tx_push and rsp_valid next cycle; stay IDLE.
  - TXDATA store with tx_full=1: latch wdata[7:0], clear timeout counter, go to TX_WAIT.
  - RXDATA load with rx_empty=0: capture rx_data, go to RX_POP.
  - All other accesses: respond next cycle; stay IDLE.
- TX_WAIT: req_ready=0. Counter increments each cycle.
  - First cycle with tx_full=0: next cycle tx_push=1 and rsp_valid=1, return to IDLE.
  - Counter reaches TX_TIMEOUT-1 with tx_full still 1: next cycle rsp_valid=1, rsp_err=1, no push, drop_sticky set, return to IDLE.
- RX_POP: req_ready=0. rx_pop=1 and rsp_valid=1 with the captured byte; IDLE next cycle.
  - This blocks a back-to-back RXDATA read from seeing the stale FIFO head.
- Sticky flags: overrun_sticky sets on rx_overrun. If a set and a W1C clear land in the same cycle, set wins.
- irq (registered): (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty & !tx_busy) | (ovr_irq_en & overrun_sticky).

## Timing
- Reset (any state): state=IDLE, req_ready=1 from the first cycle after reset.
  - rsp_valid, rsp_err, tx_push, rx_pop, irq, stickies and CTRL all reset to 0. rsp_rdata=0, tx_data=0, baud_div=DEFAULT_DIV.
- Reset during TX_WAIT or RX_POP: the operation is abandoned; no push, pop or response is issued.
- Response latency: exactly 1 cycle after accept for non-stalling accesses; rsp_valid is high for exactly 1 cycle per accepted request.
- Back-to-back: the IDLE path accepts one request per cycle. RXDATA reads with data accept at most one request every 2 cycles.
- tx_push and rx_pop never assert in the same cycle; each is high for at most 1 cycle.
- BAUD write: the new baud_div value appears 1 cycle after accept.

## Test plan
- Reset, then read STATUS with tx_empty=1, rx_empty=1 -> rdata=32'h0000_0008; baud_div=868.
- Store 0x41 to TXDATA with tx_full=0 -> cycle+1: tx_push=1, tx_data=0x41, rsp_valid=1, rsp_err=0.
- Store 0x55 with tx_full=1; drop tx_full after 10 cycles -> req_ready=0 during the stall, then one tx_push with data 0x55. With tx_full held high, the response comes after TX_TIMEOUT cycles with rsp_err=1, no push, and STATUS bit5=1.
- FIFO head 0x7E, two back-to-back RXDATA loads -> first returns 0x7E with one rx_pop; second is accepted only after RX_POP completes. With the FIFO empty, a load returns 0x8000_0000 with no pop.
- Pulse rx_overrun in the same cycle as a CTRL write of 0x104 -> overrun_sticky=1 (set wins) and irq=1 on the following cycle.
- Write 0 to BAUD -> baud_div=1. Load from offset 0x14 and store to offset 0x02 -> both respond with rsp_err=1 and no side effects.
